// File: rtl/glyph_pkg.sv
// glyph_pkg
// Shared definitions for the glyph column scanner: scan state encoding,
// default geometry and a few 5-column x 6-row glyph bitmaps for demos and
// benches. Bitmaps are listed leftmost column first, bit 5 is the top row.
package glyph_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    localparam int DEF_ROWS     = 6;
    localparam int DEF_COLS_MAX = 64;
    localparam int GLYPH_W      = 5;

    localparam logic [DEF_ROWS-1:0] GLYPH_H [GLYPH_W] = '{
        6'b111111, 6'b001000, 6'b001000, 6'b001000, 6'b111111
    };

    localparam logic [DEF_ROWS-1:0] GLYPH_I [GLYPH_W] = '{
        6'b100001, 6'b100001, 6'b111111, 6'b100001, 6'b100001
    };

endpackage

// File: rtl/glyph_col_mem.sv
// glyph_col_mem
// COLS_MAX x ROWS column bitmap store with one write port and one
// registered read port. The read register only loads when asked, so the
// displayed word stays frozen while the array underneath is rewritten.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (read register only)
//   wr_en/addr/data   column write; out-of-range addresses are dropped
//   rd_en, rd_addr    load rd_data from the array
//   rd_clr            force rd_data to zero (wins over rd_en)
//   rd_data           registered column word
module glyph_col_mem
    import glyph_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS_MAX = DEF_COLS_MAX,
    parameter int AW       = $clog2(COLS_MAX)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [ROWS-1:0] wr_data,
    input  logic            rd_en,
    input  logic            rd_clr,
    input  logic [AW-1:0]   rd_addr,
    output logic [ROWS-1:0] rd_data
);

    logic [ROWS-1:0] mem [COLS_MAX];

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < COLS_MAX)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register samples the pre-write array contents, so a write to the
    // column being entered on the same edge shows the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/glyph_scan_gen.sv
// glyph_scan_gen
// Scans a stored column bitmap out one column at a time, holding each
// column for a programmable number of cycles, once or in a loop.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en/addr/data   write a column word into the array (any state)
//   start, stop       begin a scan from IDLE / abort a running scan
//   loop_en, len, hold  scan settings, captured with an accepted start
//   row_out           current column bitmap (registered)
//   col_idx           index of the displayed column
//   active            high while scanning
//   frame_done        one-cycle pulse when a frame completes
//   frame_cnt         frames completed since start, wraps at 256
module glyph_scan_gen
    import glyph_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS_MAX = DEF_COLS_MAX,
    parameter int AW       = $clog2(COLS_MAX),
    parameter int CW       = $clog2(COLS_MAX + 1),
    parameter int HW       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [ROWS-1:0] wr_data,
    input  logic            start,
    input  logic            stop,
    input  logic            loop_en,
    input  logic [CW-1:0]   len,
    input  logic [HW-1:0]   hold,
    output logic [ROWS-1:0] row_out,
    output logic [AW-1:0]   col_idx,
    output logic            active,
    output logic            frame_done,
    output logic [7:0]      frame_cnt
);

    scan_state_t     state, state_n;
    logic [CW-1:0]   len_q;
    logic [HW-1:0]   hold_q;
    logic            loop_q;
    logic [HW-1:0]   hcnt;

    logic            start_ok;
    logic            expire;
    logic            last_col;
    logic [HW-1:0]   hold_in_eff;
    logic            load_col;
    logic [AW-1:0]   load_addr;
    logic            clear_row;
    logic            frame_end;

    // A start is only honoured with a usable length and no competing stop.
    assign start_ok    = start && !stop && (len != '0) && (len <= CW'(COLS_MAX));
    assign hold_in_eff = (hold == '0) ? HW'(1) : hold;
    // hcnt counts down the remaining cycles of the current column.
    assign expire      = (hcnt == '0);
    assign last_col    = ((CW'(col_idx) + CW'(1)) == len_q);

    // Next-state and column-load decisions. Stop outranks everything in
    // SHOW, including the end of a frame.
    always_comb begin
        state_n   = state;
        load_col  = 1'b0;
        load_addr = '0;
        clear_row = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_n  = SHOW;
                    load_col = 1'b1;
                end
            end
            SHOW: begin
                if (stop) begin
                    state_n   = IDLE;
                    clear_row = 1'b1;
                end else if (expire) begin
                    if (last_col) begin
                        frame_end = 1'b1;
                        if (loop_q) begin
                            load_col = 1'b1;
                        end else begin
                            state_n   = IDLE;
                            clear_row = 1'b1;
                        end
                    end else begin
                        load_col  = 1'b1;
                        load_addr = col_idx + AW'(1);
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                clear_row = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Scan datapath: captured settings, hold countdown, column index and
    // frame accounting. On start the hold reload comes straight from the
    // input because the captured copy is not valid until the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q      <= '0;
            hold_q     <= HW'(1);
            loop_q     <= 1'b0;
            hcnt       <= '0;
            col_idx    <= '0;
            active     <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= frame_end;
            active     <= (state_n == SHOW);

            if (state == IDLE && start_ok) begin
                len_q     <= len;
                hold_q    <= hold_in_eff;
                loop_q    <= loop_en;
                frame_cnt <= '0;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (load_col) begin
                col_idx <= load_addr;
                hcnt    <= (state == IDLE) ? (hold_in_eff - HW'(1)) : (hold_q - HW'(1));
            end else if (clear_row) begin
                col_idx <= '0;
                hcnt    <= '0;
            end else if (state == SHOW) begin
                hcnt <= hcnt - HW'(1);
            end
        end
    end

    glyph_col_mem #(
        .ROWS     (ROWS),
        .COLS_MAX (COLS_MAX),
        .AW       (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (load_col),
        .rd_clr  (clear_row),
        .rd_addr (load_addr),
        .rd_data (row_out)
    );

endmodule

// File: tb/tb_glyph_scan_gen.sv
// tb_glyph_scan_gen
// Self-checking bench for glyph_scan_gen: directed scenarios followed by a
// random phase, all compared every cycle against a frame-time reference
// model (column = elapsed / hold, frame ends at elapsed == len * hold).
module tb_glyph_scan_gen;
    import glyph_pkg::*;

    localparam int ROWS     = 6;
    localparam int COLS_MAX = 64;
    localparam int AW       = 6;
    localparam int CW       = 7;
    localparam int HW       = 8;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [ROWS-1:0] wr_data;
    logic            start;
    logic            stop;
    logic            loop_en;
    logic [CW-1:0]   len;
    logic [HW-1:0]   hold;
    logic [ROWS-1:0] row_out;
    logic [AW-1:0]   col_idx;
    logic            active;
    logic            frame_done;
    logic [7:0]      frame_cnt;

    glyph_scan_gen #(
        .ROWS(ROWS), .COLS_MAX(COLS_MAX), .AW(AW), .CW(CW), .HW(HW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stop(stop), .loop_en(loop_en),
        .len(len), .hold(hold), .row_out(row_out), .col_idx(col_idx),
        .active(active), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int m_mem [COLS_MAX];
    bit m_active;
    int m_t;
    int m_len;
    int m_hold;
    bit m_loop;
    int m_frames;
    int exp_row;
    int exp_col;
    bit exp_done;

    int n_checks;
    int n_pass;
    int act_cycles;
    int done_pulses;

    // Advance the model by one clock edge using the inputs the DUT sees.
    function automatic void modelStep();
        int l;
        exp_done = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            exp_row  = 0;
            exp_col  = 0;
            m_frames = 0;
        end else if (!m_active) begin
            l = int'(len);
            if (start && !stop && l >= 1 && l <= COLS_MAX) begin
                m_len    = l;
                m_hold   = (hold == 0) ? 1 : int'(hold);
                m_loop   = loop_en;
                m_t      = 0;
                m_frames = 0;
                m_active = 1'b1;
                exp_col  = 0;
                exp_row  = m_mem[0];
            end
        end else if (stop) begin
            m_active = 1'b0;
            exp_row  = 0;
            exp_col  = 0;
        end else begin
            m_t++;
            if (m_t == m_len * m_hold) begin
                exp_done = 1'b1;
                m_frames++;
                m_t     = 0;
                exp_col = 0;
                if (m_loop) begin
                    exp_row = m_mem[0];
                end else begin
                    m_active = 1'b0;
                    exp_row  = 0;
                end
            end else if (m_t % m_hold == 0) begin
                exp_col = m_t / m_hold;
                exp_row = m_mem[exp_col];
            end
        end
        if (wr_en && int'(wr_addr) < COLS_MAX) begin
            m_mem[wr_addr] = int'(wr_data);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Run a number of cycles; strobes are cleared after each edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            modelStep();
            #1;
            checkOutput("row_out",    32'(row_out),    32'(exp_row));
            checkOutput("col_idx",    32'(col_idx),    32'(exp_col));
            checkOutput("active",     32'(active),     32'(m_active));
            checkOutput("frame_done", 32'(frame_done), 32'(exp_done));
            checkOutput("frame_cnt",  32'(frame_cnt),  32'(m_frames % 256));
            if (active) act_cycles++;
            if (frame_done) done_pulses++;
            start = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
            rst_n = 1'b1;
        end
    endtask

    // Step until the given column has just been entered, within a budget.
    task automatic waitForCol(input int target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            applyStimulus(1);
            if (active && int'(col_idx) == target) hit = 1'b1;
        end
        if (!hit) checkOutput("wait_col", {25'd0, active, col_idx}, {25'd0, 1'b1, AW'(target)});
    endtask

    task automatic doStart(input int l, input int h, input bit lp);
        start   = 1'b1;
        len     = CW'(l);
        hold    = HW'(h);
        loop_en = lp;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; len = '0; hold = '0;
        n_checks = 0; n_pass = 0; act_cycles = 0; done_pulses = 0;
        m_active = 1'b0; m_t = 0; m_len = 1; m_hold = 1; m_loop = 1'b0;
        m_frames = 0; exp_row = 0; exp_col = 0; exp_done = 1'b0;
        for (int i = 0; i < COLS_MAX; i++) m_mem[i] = 0;

        rst_n = 1'b0; applyStimulus(1);
        rst_n = 1'b0; applyStimulus(1);
        checkOutput("reset_row",    32'(row_out),   0);
        checkOutput("reset_active", 32'(active),    0);
        checkOutput("reset_fcnt",   32'(frame_cnt), 0);

        // Fill the whole array: a bar pattern, two glyphs, random rest.
        for (int i = 0; i < COLS_MAX; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            if (i == 0 || i == 3)      wr_data = 6'b111111;
            else if (i < 3)            wr_data = 6'b001000;
            else if (i < 4 + GLYPH_W)  wr_data = GLYPH_H[i - 4];
            else if (i < 4 + 2*GLYPH_W) wr_data = GLYPH_I[i - 4 - GLYPH_W];
            else                       wr_data = ROWS'($urandom);
            applyStimulus(1);
        end

        // One-shot scan of 4 columns, 3 cycles each.
        act_cycles = 0; done_pulses = 0;
        doStart(4, 3, 1'b0); applyStimulus(1);
        checkOutput("oneshot_first", 32'(row_out), 32'h3f);
        applyStimulus(15);
        checkOutput("oneshot_active_cycles", act_cycles, 12);
        checkOutput("oneshot_done_pulses", done_pulses, 1);
        checkOutput("oneshot_fcnt", 32'(frame_cnt), 1);
        checkOutput("oneshot_row_idle", 32'(row_out), 0);

        // Reset in the middle of a looping scan.
        doStart(4, 3, 1'b1); applyStimulus(1); applyStimulus(14);
        rst_n = 1'b0; applyStimulus(1);
        checkOutput("midreset_row", 32'(row_out), 0);
        checkOutput("midreset_active", 32'(active), 0);
        checkOutput("midreset_fcnt", 32'(frame_cnt), 0);
        doStart(4, 1, 1'b0); applyStimulus(1); applyStimulus(5);
        checkOutput("after_reset_fcnt", 32'(frame_cnt), 1);

        // Two-column loop with hold 0: 256 frames wrap the counter.
        doStart(2, 0, 1'b1); applyStimulus(1); applyStimulus(512);
        checkOutput("wrap_fcnt", 32'(frame_cnt), 0);
        checkOutput("wrap_done", 32'(frame_done), 1);
        stop = 1'b1; applyStimulus(1);

        // Stop during column 1, then starts that must be ignored.
        doStart(4, 3, 1'b0); applyStimulus(1); applyStimulus(3);
        stop = 1'b1; applyStimulus(1);
        checkOutput("stop_active", 32'(active), 0);
        checkOutput("stop_done", 32'(frame_done), 0);
        doStart(0, 2, 1'b0); applyStimulus(3);
        checkOutput("len0_active", 32'(active), 0);
        doStart(3, 2, 1'b0); stop = 1'b1; applyStimulus(2);
        checkOutput("startstop_active", 32'(active), 0);

        // Start while active does not restart the scan.
        doStart(4, 3, 1'b1); applyStimulus(1); applyStimulus(2);
        doStart(1, 1, 1'b0); applyStimulus(1);
        checkOutput("restart_col", 32'(col_idx), 1);
        stop = 1'b1; applyStimulus(1);

        // Single column, hold 1, loop; stop at a frame end suppresses frame_done.
        doStart(1, 1, 1'b1); applyStimulus(1); applyStimulus(3);
        checkOutput("single_done", 32'(frame_done), 1);
        stop = 1'b1; applyStimulus(1);
        checkOutput("stop_at_end_done", 32'(frame_done), 0);

        // Writes to the displayed column and on the wrap edge.
        doStart(4, 3, 1'b1); applyStimulus(1); applyStimulus(6);
        wr_en = 1'b1; wr_addr = 6'd2; wr_data = 6'b010101; applyStimulus(1);
        checkOutput("collide_hold_row", 32'(row_out), 32'h08);
        waitForCol(3, 20); waitForCol(2, 20);
        checkOutput("collide_next_pass", 32'(row_out), 32'h15);
        waitForCol(3, 20); applyStimulus(2);
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 6'b000111; applyStimulus(1);
        checkOutput("wrap_write_col", 32'(col_idx), 0);
        checkOutput("wrap_write_row", 32'(row_out), 32'h3f);
        waitForCol(1, 20); waitForCol(0, 20);
        checkOutput("wrap_write_next", 32'(row_out), 32'h07);
        stop = 1'b1; applyStimulus(1);

        // Full depth one-shot, then an oversize length.
        act_cycles = 0; done_pulses = 0;
        doStart(COLS_MAX, 1, 1'b0); applyStimulus(1); applyStimulus(65);
        checkOutput("full_active_cycles", act_cycles, 64);
        checkOutput("full_done_pulses", done_pulses, 1);
        doStart(COLS_MAX + 1, 1, 1'b0); applyStimulus(2);
        checkOutput("len65_active", 32'(active), 0);

        // Random phase.
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = AW'($urandom);
            wr_data = ROWS'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                doStart($urandom_range(0, 70), $urandom_range(0, 4), 1'($urandom));
            end
            stop = ($urandom_range(0, 39) == 0);
            applyStimulus(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/glyph_scan_gen.md
Name: glyph_scan_gen

Overview:
Synthesizable, parametrised successor to the hand-timed waveform glyph drawing in our test benches. It stores a column bitmap (one ROWS-wide word per column) in an internal array and scans it out column by column. Each column is held for a runtime-programmable number of cycles, in one-shot or looping mode. The block drives banner/dot-matrix style row outputs in simulation displays and on-board LED matrices.

Parameters:
ROWS, 6, number of row outputs (bits per column word)
COLS_MAX, 64, column array depth
AW, $clog2(COLS_MAX), column address width
CW, $clog2(COLS_MAX+1), column-count width
HW, 8, hold-count width

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  synchronous, active-low reset
wr_en  input  1  write strobe into column array
wr_addr  input  AW  column address to write
wr_data  input  ROWS  column bitmap; bit ROWS-1 = top row
start  input  1  begin scan (IDLE only)
stop  input  1  abort scan
loop_en  input  1  1 = repeat frames, 0 = one frame; sampled with start
len  input  CW  columns per frame, 1..COLS_MAX; sampled with start
hold  input  HW  cycles per column; 0 treated as 1; sampled with start
row_out  output  ROWS  registered current column bitmap
col_idx  output  AW  registered index of the displayed column
active  output  1  high while scanning
frame_done  output  1  one-cycle pulse at end of each frame
frame_cnt  output  8  completed frames since start, wraps 255->0

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; row_out=0, col_idx=0, active=0, frame_done=0, frame_cnt=0. Array contents are not reset. Reset takes priority over everything, including mid-scan.
- Array writes: on any cycle with wr_en=1, regardless of state. A write with wr_addr>=COLS_MAX is dropped.
- States: IDLE, SHOW.
- IDLE:
  - start=1, stop=0, len in 1..COLS_MAX -> latch len, hold_eff=max(hold,1) and loop_en; clear frame_cnt.
  - Next cycle: SHOW, active=1, col_idx=0, row_out=mem[0].
  - Latency from start sampled to first column: 1 cycle.
  - start with len=0 or len>COLS_MAX is ignored. start with stop=1 is ignored.
- SHOW:
  - A hold counter runs. Each column is presented for exactly hold_eff cycles.
  - On expiry with col_idx<len-1: col_idx+1, and row_out loads mem[col_idx+1].
  - On expiry of column len-1:
    - frame_done=1 for one cycle, and frame_cnt increments.
    - If latched loop=1: col_idx=0, row_out=mem[0] in that same cycle; no idle gap.
    - If loop=0: IDLE, active=0, row_out=0, col_idx=0.
  - stop=1: next cycle IDLE, active=0, row_out=0, col_idx=0, frame_done stays 0, and frame_cnt holds its value.
  - stop coincident with frame end: stop wins, and no frame_done.
  - start in SHOW is ignored. len, hold and loop_en changes in SHOW have no effect until the next start.
- Read/write collision: row_out is sampled from the array only on column entry. A write to the displayed column does not alter row_out until that column is re-entered. A same-cycle write to the column being entered returns the old data (read-before-write).
- len=1, hold=1, loop=1: row_out constant at mem[0], and frame_done is high every cycle.
- Total frame length = len*hold_eff cycles.

Decomposition:
- Shared package glyph_pkg: state enum (IDLE, SHOW), default ROWS/COLS_MAX constants, and a 5x6 glyph-column constant set for bench and demo use.
- Natural sub-module: glyph_col_mem, a COLS_MAX x ROWS register array with 1 write port and 1 synchronous-on-demand read port. The FSM, hold counter, column counter and frame counter stay in glyph_scan_gen.

Test Plan:
- Reset mid-scan: scan running with hold=3, rst_n=0 for 1 cycle -> next cycle row_out=0, active=0, frame_cnt=0; a later start works normally.
- One-shot scan: write cols 0..3 = 6'b111111, 6'b001000, 6'b001000, 6'b111111; len=4, hold=3, loop_en=0, start -> 1 cycle later row_out=6'b111111 for 3 cycles, then 6'b001000 x6 cycles, then 6'b111111 x3. Then frame_done pulses once, active=0, row_out=0; 12 active cycles total; frame_cnt=1.
- Loop and wrap: len=2, hold=0 (acts as 1), loop_en=1 -> row_out alternates mem[0]/mem[1] every cycle; frame_done every 2nd cycle; frame_cnt wraps 255->0 after 256 frames.
- Stop and ignored starts: stop during column 1 -> next cycle idle with no frame_done. start with len=0 -> active stays 0. start while active -> no restart, col_idx continues.
- Write collision: during hold of col 2, write col 2=6'b010101 -> row_out unchanged. On the next loop pass, col 2 shows 6'b010101. A write to col 0 on the exact wrap cycle -> old value shown that pass.
- Full depth: len=COLS_MAX=64, hold=1, loop_en=0 -> col_idx runs 0..63 with no skips; frame_done exactly 64 cycles after first column; len=65 ignored.
